// File: rtl/clk_map_pkg.sv
// clk_map_pkg: shared FSM states and PIO edge-capture register constants for clk_map_poller.
package clk_map_pkg;
  typedef enum logic [1:0] {IDLE, RD, WAIT, CLR} state_t;
  localparam logic [1:0] DATA = 2'd0;
  localparam logic [1:0] EDGE_CAP = 2'd3;
  localparam logic [31:0] CLR_WORD = 32'h1;
endpackage

// File: rtl/clk_map_gate_timer.sv
// clk_map_gate_timer: counts enabled clk cycles and pulses expire on the last cycle of each gate window.
module clk_map_gate_timer #(
  parameter int GATE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(GATE_CYCLES);
  logic [W-1:0] cnt;
  assign expire = enable && cnt == W'(GATE_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else cnt <= (!enable || expire) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/clk_map_poller.sv
// clk_map_poller: polls a PIO edge-capture register, clears it on each hit and reports hits per gate window.
// Defining CLK_MAP_POLLER_IRQ_EN adds the irq/irq_ack interrupt ports.
module clk_map_poller
  import clk_map_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic [1:0] pio_address,
  output logic pio_chipselect,
  output logic pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic [CNT_W-1:0] result,
  output logic result_valid,
  output logic busy
`ifdef CLK_MAP_POLLER_IRQ_EN
  ,
  input  logic irq_ack,
  output logic irq
`endif
);
  state_t state, next;
  logic expire, flag, hit, unused_rdata;
  logic [CNT_W-1:0] events, closing;
  assign flag = pio_readdata[0];
  assign unused_rdata = ^pio_readdata[31:1];
  assign hit = state == WAIT && flag;
  // a hit on the expiry cycle still belongs to the window being closed
  assign closing = (hit && events != '1) ? events + 1'b1 : events;
  clk_map_gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_gate (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    pio_chipselect = 1'b0;
    pio_write_n = 1'b1;
    pio_address = DATA;
    pio_writedata = '0;
    busy = state != IDLE;
    next = state == IDLE ? (enable ? RD : IDLE) :
           state == RD   ? WAIT :
           state == WAIT ? (flag ? CLR : (enable ? RD : IDLE)) :
                           (enable ? RD : IDLE);
    pio_chipselect = state == RD || state == CLR;
    pio_write_n = state != CLR;
    pio_address = pio_chipselect ? EDGE_CAP : DATA;
    pio_writedata = state == CLR ? CLR_WORD : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      events <= '0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= expire;
      if (expire) result <= closing;
      events <= (!enable || expire) ? '0 : closing;
    end
  end
`ifdef CLK_MAP_POLLER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else irq <= result_valid || (irq && !irq_ack);
  end
`endif
endmodule

// File: tb/tb_clk_map_poller.sv
// tb_clk_map_poller: randomized self-checking bench with a PIO edge-capture model and a transaction-level count model.
module tb_clk_map_poller;
  localparam int G = 100;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [1:0] addr, addr4;
  logic cs, wn, cs4, wn4;
  logic [31:0] wdata, wdata4;
  logic [31:0] rdata = 32'h0, rdata4 = 32'h0;
  logic [15:0] result;
  logic [3:0] result4;
  logic rv, rv4, busy, busy4;
  logic irq_ack = 1'b0;
  logic irq, irq4;
  logic edge_in = 1'b0, flush = 1'b0, cap = 1'b0;
  int wr_cnt = 0, bad_wr = 0;
  int checks = 0, errors = 0;
  int last_exp = 0;
  bit edge_bits [0:G-1];
  bit cs_tr [0:G-1];
  bit wn_tr [0:G-1];
  logic [1:0] addr_tr [0:G-1];
  int early_rv;

  always #5 clk = ~clk;

  clk_map_poller #(.GATE_CYCLES(G), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(addr), .pio_chipselect(cs), .pio_write_n(wn), .pio_writedata(wdata),
    .pio_readdata(rdata), .result(result), .result_valid(rv), .busy(busy)
`ifdef CLK_MAP_POLLER_IRQ_EN
    , .irq_ack(irq_ack), .irq(irq)
`endif
  );

  clk_map_poller #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(addr4), .pio_chipselect(cs4), .pio_write_n(wn4), .pio_writedata(wdata4),
    .pio_readdata(rdata4), .result(result4), .result_valid(rv4), .busy(busy4)
`ifdef CLK_MAP_POLLER_IRQ_EN
    , .irq_ack(1'b0), .irq(irq4)
`endif
  );

`ifndef CLK_MAP_POLLER_IRQ_EN
  assign irq = 1'b0;
  assign irq4 = 1'b0;
`endif

  // PIO edge-capture slave: a new edge wins over a simultaneous clear write
  always @(posedge clk) begin
    cap <= flush ? 1'b0 : (edge_in | (cap & !(cs && !wn && addr == 2'd3 && wdata == 32'h1)));
    rdata <= (cs && wn && addr == 2'd3) ? {31'b0, cap} : 32'h0;
    rdata4 <= (cs4 && wn4 && addr4 == 2'd3) ? 32'h1 : 32'h0;
    if (cs && !wn) begin
      wr_cnt <= wr_cnt + 1;
      if (addr != 2'd3 || wdata != 32'h1) bad_wr <= bad_wr + 1;
    end
  end

  // Walks poll transactions through the window: a read takes 2 cycles, a hit adds a clear cycle.
  function automatic int model_count();
    int cnt = 0, rd = 0, smp = -1, clr = -1;
    bit c = 1'b0, flg = 1'b0;
    for (int k = 0; k < G; k++) begin
      if (k == rd + 1) begin
        flg = c;
        smp = k + 1;
      end
      if (k == smp) begin
        if (flg) begin
          cnt++;
          clr = k + 1;
          rd = k + 1;
        end else rd = k;
      end
      c = edge_bits[k] | (c & (k != clr));
    end
    return cnt;
  endfunction

  task automatic run_window();
    early_rv = 0;
    @(negedge clk);
    enable = 1'b1;
    edge_in = edge_bits[0];
    for (int k = 0; k < G; k++) begin
      @(posedge clk);
      #1;
      cs_tr[k] = cs;
      wn_tr[k] = wn;
      addr_tr[k] = addr;
      if (k < G - 1) begin
        if (rv) early_rv++;
        edge_in = edge_bits[k + 1];
      end else edge_in = 1'b0;
    end
  endtask

  task automatic end_window();
    @(negedge clk);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (cs !== 1'b0 || wn !== 1'b1 || addr !== 2'd0 || wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: cs=%b wn=%b addr=%0d wdata=%h, want 0 1 0 0", cs, wn, addr, wdata);
    end
    checks++;
    if (busy !== 1'b0 || rv !== 1'b0 || result !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rv=%b result=%0d, want 0 0 0", busy, rv, result);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_poll();
    int bad = 0, w0;
    for (int k = 0; k < G; k++) edge_bits[k] = 1'b0;
    w0 = wr_cnt;
    run_window();
    for (int k = 0; k < G; k++)
      if (cs_tr[k] !== (k % 2 == 0) || wn_tr[k] !== 1'b1 || addr_tr[k] !== ((k % 2 == 0) ? 2'd3 : 2'd0)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_seq: %0d cycles off the RD,WAIT pattern, want 0", bad);
    end
    checks++;
    if (rv !== 1'b1 || early_rv != 0) begin
      errors++;
      $display("FAIL idle_rv: rv=%b early=%0d, want 1 0", rv, early_rv);
    end
    checks++;
    if (result !== 16'd0) begin
      errors++;
      $display("FAIL idle_result: got %0d want 0", result);
    end
    checks++;
    if (wr_cnt - w0 != 0) begin
      errors++;
      $display("FAIL idle_writes: got %0d want 0", wr_cnt - w0);
    end
    last_exp = 0;
    end_window();
  endtask

  task automatic test_edges();
    int w0, b0;
    for (int k = 0; k < G; k++) edge_bits[k] = (k % 10 == 0);
    w0 = wr_cnt;
    b0 = bad_wr;
    run_window();
    checks++;
    if (rv !== 1'b1 || result !== 16'd10) begin
      errors++;
      $display("FAIL edges_result: rv=%b result=%0d, want 1 10", rv, result);
    end
    checks++;
    if (wr_cnt - w0 != 10 || bad_wr != b0) begin
      errors++;
      $display("FAIL edges_writes: writes=%0d bad=%0d, want 10 0", wr_cnt - w0, bad_wr - b0);
    end
    last_exp = 10;
    end_window();
  endtask

  task automatic test_saturate();
    int exp;
    for (int k = 0; k < G; k++) edge_bits[k] = ($urandom_range(0, 5) == 0);
    exp = model_count();
    run_window();
    checks++;
    if (rv4 !== 1'b1 || result4 !== 4'd15) begin
      errors++;
      $display("FAIL saturate: rv=%b result=%0d, want 1 15", rv4, result4);
    end
    checks++;
    if (result !== 16'(exp)) begin
      errors++;
      $display("FAIL sat_main: got %0d want %0d", result, exp);
    end
    last_exp = exp;
    end_window();
  endtask

  task automatic test_back_to_back();
    int exp;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < G; k++) edge_bits[k] = ($urandom_range(0, 2 + t * 2) == 0);
      exp = model_count();
      run_window();
      checks++;
      if (rv !== 1'b1 || early_rv != 0 || result !== 16'(exp)) begin
        errors++;
        $display("FAIL random_%0d: rv=%b early=%0d result=%0d, want 1 0 %0d", t, rv, early_rv, result, exp);
      end
      last_exp = exp;
      end_window();
    end
  endtask

  task automatic test_enable_drop_clr();
    int w0, pulses = 0;
    w0 = wr_cnt;
    @(negedge clk);
    enable = 1'b1;
    edge_in = 1'b1;
    @(posedge clk);
    #1 edge_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cs !== 1'b1 || wn !== 1'b0) begin
      errors++;
      $display("FAIL drop_in_clr: cs=%b wn=%b, want 1 0", cs, wn);
    end
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || wr_cnt - w0 != 1) begin
      errors++;
      $display("FAIL drop_idle: busy=%b writes=%0d, want 0 1", busy, wr_cnt - w0);
    end
    for (int k = 0; k < 2 * G; k++) begin
      @(posedge clk);
      #1 if (rv) pulses++;
    end
    checks++;
    if (pulses != 0 || result !== 16'(last_exp)) begin
      errors++;
      $display("FAIL drop_hold: pulses=%0d result=%0d, want 0 %0d", pulses, result, last_exp);
    end
    end_window();
  endtask

  task automatic test_reset_rd();
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    enable = 1'b1;
    edge_in = 1'b1;
    @(posedge clk);
    #1 edge_in = 1'b0;
    #1;
    checks++;
    if (cs !== 1'b1 || wn !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_rd: cs=%b wn=%b busy=%b, want 1 1 1", cs, wn, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (cs !== 1'b0 || wn !== 1'b1 || addr !== 2'd0 || wdata !== 32'h0 || busy !== 1'b0 || rv !== 1'b0 || result !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_rd: cs=%b wn=%b addr=%0d wdata=%h busy=%b rv=%b result=%0d, want all reset values",
               cs, wn, addr, wdata, busy, rv, result);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt - w0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_write: writes=%0d busy=%b, want 0 0", wr_cnt - w0, busy);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    last_exp = 0;
    end_window();
  endtask

`ifdef CLK_MAP_POLLER_IRQ_EN
  task automatic test_irq();
    for (int k = 0; k < G; k++) edge_bits[k] = 1'b0;
    run_window();
    irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins: got %b want 1", irq);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold: got %b want 1", irq);
    end
    irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
    end_window();
  endtask
`endif

  initial begin
    test_reset();
    test_idle_poll();
    test_edges();
    test_saturate();
    test_back_to_back();
    test_enable_drop_clr();
    test_reset_rd();
`ifdef CLK_MAP_POLLER_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
